dma_read_scheduler: RTL and testbench

//  Shares one AXI DMA read engine among NumReq requesters. Each requester posts {addr,len}

---
 rtl/dma_sched_pkg.sv | 20 ++
 rtl/dma_read_scheduler_rr_arbiter.sv | 40 ++++
 rtl/dma_read_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_dma_read_scheduler.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_sched_pkg.sv
// Shared types and helpers for the DMA read scheduler: FSM states, tag width
// and packed-vector slicing.
package dma_sched_pkg;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ZCPL  = 2'd2
    } sched_state_t;

    function automatic int tag_bits(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Low bit of lane idx inside a packed per-requester vector.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/dma_read_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping
// cyclically, and reports both the one-hot grant and its index.
module rr_arbiter
    import dma_sched_pkg::*;
#(
    parameter  int NumReq  = 4,
    localparam int IdxBits = tag_bits(NumReq)
) (
    input  logic [NumReq-1:0]  req,
    input  logic [IdxBits-1:0] ptr,
    input  logic               en,
    output logic [NumReq-1:0]  grant,
    output logic [IdxBits-1:0] idx,
    output logic               any
);

    logic [NumReq-1:0]  mask;
    logic [NumReq-1:0]  hi;
    logic [IdxBits-1:0] hi_idx;
    logic [IdxBits-1:0] lo_idx;

    always_comb begin
        mask   = '0;
        hi_idx = '0;
        lo_idx = '0;
        for (int k = 0; k < NumReq; k++) begin
            mask[k] = (k >= int'(ptr));
        end
        hi = req & mask;
        // Scan downwards so the lowest set bit wins.
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (hi[k])  hi_idx = IdxBits'(k);
            if (req[k]) lo_idx = IdxBits'(k);
        end
        any   = en && (|req);
        idx   = (|hi) ? hi_idx : lo_idx;
        grant = any ? (NumReq'(1) << idx) : '0;
    end

endmodule

// File: rtl/dma_read_scheduler.sv
// Shares one DMA read engine among NumReq requesters: round-robin descriptor
// issue, per-beat owner tagging and per-requester completion pulses.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_ARB   | pick next requester (needs a free tag slot)
//   ST_ISSUE | hold latched descriptor on cfg port until the engine takes it
//   ST_ZCPL  | zero-length descriptor: complete locally, nothing forwarded
module dma_read_scheduler
    import dma_sched_pkg::*;
#(
    parameter  int NumReq     = 4,
    parameter  int AddrBits   = 32,
    parameter  int LengthBits = 16,
    parameter  int TagDepth   = 4,
    localparam int TagBits    = tag_bits(NumReq)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NumReq-1:0]            req_valid,
    output logic [NumReq-1:0]            req_ready,
    input  logic [NumReq*AddrBits-1:0]   req_addr,
    input  logic [NumReq*LengthBits-1:0] req_len,
    output logic                         dma_cfg_valid,
    input  logic                         dma_cfg_ready,
    output logic [AddrBits-1:0]          dma_cfg_addr,
    output logic [LengthBits-1:0]        dma_cfg_len,
    input  logic                         dma_dout_valid,
    input  logic                         dma_dout_ready,
    input  logic                         dma_dout_eof,
    output logic [TagBits-1:0]           dout_tag,
    output logic                         dout_tag_valid,
    output logic [NumReq-1:0]            cpl,
    output logic                         busy
);

    localparam int PtrBits = (TagDepth > 1) ? $clog2(TagDepth) : 1;
    localparam int CntBits = $clog2(TagDepth) + 1;

    sched_state_t          state_q, state_d;
    logic [1:0]            run_q;
    logic [TagBits-1:0]    rr_ptr_q, g_q, grant_idx;
    logic [NumReq-1:0]     grant_oh;
    logic                  grant_any, grant_en;
    logic [AddrBits-1:0]   addr_q, sel_addr;
    logic [LengthBits-1:0] len_q, sel_len;

    logic [TagBits-1:0]    fifo_q [TagDepth];
    logic [PtrBits-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CntBits-1:0]    count_q;
    logic                  fifo_full, fifo_empty, push, pop, eof_hs;

    logic                  drain_v_q;
    logic [TagBits-1:0]    drain_tag_q;
    logic [1:0]            pend_q [NumReq];
    logic [1:0]            pend_d [NumReq];
    logic [NumReq-1:0]     zcpl_vec, drain_vec;

    // Reset is released synchronously: no grant until two clean edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_q <= '0;
        else        run_q <= {run_q[0], 1'b1};
    end

    assign fifo_full  = (count_q == CntBits'(TagDepth));
    assign fifo_empty = (count_q == '0);
    assign grant_en   = (state_q == ST_ARB) && run_q[1] && !fifo_full;

    rr_arbiter #(.NumReq(NumReq)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .en    (grant_en),
        .grant (grant_oh),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    assign req_ready = grant_oh;

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (grant_idx == TagBits'(i)) begin
                sel_addr = req_addr[slice_lo(i, AddrBits) +: AddrBits];
                sel_len  = req_len[slice_lo(i, LengthBits) +: LengthBits];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        dma_cfg_valid = 1'b0;
        unique case (state_q)
            ST_ARB:   if (grant_any) state_d = (sel_len == '0) ? ST_ZCPL : ST_ISSUE;
            ST_ISSUE: begin
                dma_cfg_valid = 1'b1;
                if (dma_cfg_ready) state_d = ST_ARB;
            end
            ST_ZCPL:  state_d = ST_ARB;
            default:  state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_ARB;
            rr_ptr_q <= '0;
            g_q      <= '0;
            addr_q   <= '0;
            len_q    <= '0;
        end else begin
            state_q <= state_d;
            if (grant_any) begin
                g_q      <= grant_idx;
                addr_q   <= sel_addr;
                len_q    <= sel_len;
                rr_ptr_q <= (grant_idx == TagBits'(NumReq - 1)) ? '0 : grant_idx + TagBits'(1);
            end
        end
    end

    assign dma_cfg_addr = addr_q;
    assign dma_cfg_len  = len_q;

    assign push   = (state_q == ST_ISSUE) && dma_cfg_ready;
    assign eof_hs = dma_dout_valid && dma_dout_ready && dma_dout_eof;
    assign pop    = eof_hs && !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TagDepth; i++) fifo_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            drain_v_q   <= 1'b0;
            drain_tag_q <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= g_q;
                wr_ptr_q         <= wr_ptr_q + PtrBits'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PtrBits'(1);
            count_q     <= count_q + CntBits'(push) - CntBits'(pop);
            drain_v_q   <= pop;
            drain_tag_q <= fifo_q[rd_ptr_q];
        end
    end

    assign dout_tag       = fifo_q[rd_ptr_q];
    assign dout_tag_valid = !fifo_empty;
    assign busy           = (state_q != ST_ARB) || !fifo_empty;

    // A requester can owe more than one pulse in a cycle (zero-length and
    // drain completions colliding); the surplus is carried and paid later.
    always_comb begin
        zcpl_vec  = '0;
        drain_vec = '0;
        cpl       = '0;
        pend_d    = pend_q;
        for (int i = 0; i < NumReq; i++) begin
            zcpl_vec[i]  = (state_q == ST_ZCPL) && (g_q == TagBits'(i));
            drain_vec[i] = drain_v_q && (drain_tag_q == TagBits'(i));
            cpl[i]       = zcpl_vec[i] || drain_vec[i] || (pend_q[i] != 2'd0);
            pend_d[i]    = pend_q[i] + {1'b0, zcpl_vec[i]} + {1'b0, drain_vec[i]}
                           - {1'b0, cpl[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NumReq; i++) pend_q[i] <= 2'd0;
        end else begin
            pend_q <= pend_d;
        end
    end

`ifndef SYNTHESIS
    eof_without_tag: assert property (@(posedge clk) disable iff (!rst_n)
        !(eof_hs && fifo_empty));
`endif

endmodule

// File: tb/tb_dma_read_scheduler.sv
// Directed bench for dma_read_scheduler: simple requester and engine models
// log grants, descriptors, tagged beats and completions for hand-checked tests.
module tb_dma_read_scheduler;

    localparam int NumReq     = 4;
    localparam int AddrBits   = 32;
    localparam int LengthBits = 16;
    localparam int TagDepth   = 4;
    localparam int TagBits    = 2;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b1;
    logic [NumReq-1:0]            req_valid, req_ready;
    logic [NumReq*AddrBits-1:0]   req_addr;
    logic [NumReq*LengthBits-1:0] req_len;
    logic                         dma_cfg_valid, dma_cfg_ready;
    logic [AddrBits-1:0]          dma_cfg_addr;
    logic [LengthBits-1:0]        dma_cfg_len;
    logic                         dma_dout_valid, dma_dout_ready, dma_dout_eof;
    logic [TagBits-1:0]           dout_tag;
    logic                         dout_tag_valid;
    logic [NumReq-1:0]            cpl;
    logic                         busy;

    always #5 clk = ~clk;

    dma_read_scheduler #(
        .NumReq(NumReq), .AddrBits(AddrBits), .LengthBits(LengthBits), .TagDepth(TagDepth)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .dma_cfg_valid(dma_cfg_valid), .dma_cfg_ready(dma_cfg_ready),
        .dma_cfg_addr(dma_cfg_addr), .dma_cfg_len(dma_cfg_len),
        .dma_dout_valid(dma_dout_valid), .dma_dout_ready(dma_dout_ready),
        .dma_dout_eof(dma_dout_eof),
        .dout_tag(dout_tag), .dout_tag_valid(dout_tag_valid), .cpl(cpl), .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int              pend     [NumReq];
    logic [31:0]     addr_tab [NumReq];
    logic [15:0]     len_tab  [NumReq];
    logic            cfg_rdy, stall;
    bit              beats[$];
    int              grant_log[$], grant_cyc[$], cfg_cyc[$], tag_log[$], eof_cyc[$];
    int              cpl_log[$], cpl_cyc[$];
    logic [31:0]     cfg_addr_log[$];
    logic [15:0]     cfg_len_log[$];
    int              multi_grant, tag_invalid, cfg_valid_cycles;
    logic            s_cfg_valid, s_tag_valid;
    logic [31:0]     s_cfg_addr;
    logic [15:0]     s_cfg_len;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NumReq; i++) begin
            pend[i] = 0; addr_tab[i] = '0; len_tab[i] = '0;
        end
        cfg_rdy = 1'b1; stall = 1'b0;
        beats.delete(); grant_log.delete(); grant_cyc.delete(); cfg_cyc.delete();
        tag_log.delete(); eof_cyc.delete(); cpl_log.delete(); cpl_cyc.delete();
        cfg_addr_log.delete(); cfg_len_log.delete();
        multi_grant = 0; tag_invalid = 0; cfg_valid_cycles = 0;
        s_cfg_valid = 0; s_tag_valid = 0; s_cfg_addr = '0; s_cfg_len = '0;
        req_valid = '0; req_addr = '0; req_len = '0;
        dma_cfg_ready = 1'b0; dma_dout_valid = 1'b0; dma_dout_ready = 1'b0; dma_dout_eof = 1'b0;
    endtask

    // Called at posedge+1: drive, let settle, sample, advance one clock.
    task automatic one_cycle();
        int ones;
        int len;
        for (int i = 0; i < NumReq; i++) begin
            req_valid[i] = (pend[i] != 0);
            req_addr[i*AddrBits +: AddrBits]     = addr_tab[i];
            req_len[i*LengthBits +: LengthBits]  = len_tab[i];
        end
        dma_cfg_ready  = cfg_rdy;
        dma_dout_valid = (beats.size() != 0);
        dma_dout_eof   = (beats.size() != 0) ? beats[0] : 1'b0;
        dma_dout_ready = !stall;
        #1;
        ones = 0;
        for (int i = 0; i < NumReq; i++) begin
            if (req_ready[i]) begin
                ones++;
                grant_log.push_back(i);
                grant_cyc.push_back(cyc);
                pend[i]--;
            end
        end
        if (ones > 1) multi_grant++;
        if (dma_cfg_valid) cfg_valid_cycles++;
        if (dma_cfg_valid && dma_cfg_ready) begin
            cfg_addr_log.push_back(dma_cfg_addr);
            cfg_len_log.push_back(dma_cfg_len);
            cfg_cyc.push_back(cyc);
            len = int'(dma_cfg_len);
            for (int b = 0; b < len; b++) beats.push_back(b == len - 1);
        end
        if (dma_dout_valid && dma_dout_ready) begin
            tag_log.push_back(int'(dout_tag));
            if (!dout_tag_valid) tag_invalid++;
            if (dma_dout_eof) eof_cyc.push_back(cyc);
            void'(beats.pop_front());
        end
        if (cpl != '0) begin
            cpl_log.push_back(int'(cpl));
            cpl_cyc.push_back(cyc);
        end
        s_cfg_valid = dma_cfg_valid; s_cfg_addr = dma_cfg_addr;
        s_cfg_len   = dma_cfg_len;   s_tag_valid = dout_tag_valid;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        repeat (3) one_cycle();
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check_eq({tag, "_cfg_valid"}, dma_cfg_valid, 0);
        check_eq({tag, "_req_ready"}, req_ready, 0);
        check_eq({tag, "_cpl"}, cpl, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_tag_valid"}, dout_tag_valid, 0);
        release_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, reached cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        #1;

        // Test 1: requesters 0 and 2, 16 words each.
        do_reset("t1_rst");
        addr_tab[0] = 32'h1000; len_tab[0] = 16; pend[0] = 1;
        addr_tab[2] = 32'h2000; len_tab[2] = 16; pend[2] = 1;
        repeat (60) one_cycle();
        check_eq("t1_cfg_count", cfg_addr_log.size(), 2);
        check_eq("t1_cfg0_addr", cfg_addr_log[0], 32'h1000);
        check_eq("t1_cfg0_len", cfg_len_log[0], 16);
        check_eq("t1_cfg1_addr", cfg_addr_log[1], 32'h2000);
        check_eq("t1_cfg1_len", cfg_len_log[1], 16);
        check_eq("t1_beats", tag_log.size(), 32);
        bad = 0;
        foreach (tag_log[k]) if (tag_log[k] != ((k < 16) ? 0 : 2)) bad++;
        check_eq("t1_tag_seq", bad, 0);
        check_eq("t1_tag_valid", tag_invalid, 0);
        check_eq("t1_cpl_count", cpl_log.size(), 2);
        check_eq("t1_cpl_first", cpl_log[0], 4'b0001);
        check_eq("t1_cpl_second", cpl_log[1], 4'b0100);
        check_eq("t1_busy_end", busy, 0);

        // Test 2: all four requesters, two 8-word frames each.
        do_reset("t2_rst");
        for (int i = 0; i < NumReq; i++) begin
            addr_tab[i] = 32'h4000 + 32'(i) * 32'h100; len_tab[i] = 8; pend[i] = 2;
        end
        repeat (110) one_cycle();
        check_eq("t2_grant_count", grant_log.size(), 8);
        bad = 0;
        foreach (grant_log[k]) if (grant_log[k] != (k % 4)) bad++;
        check_eq("t2_grant_order", bad, 0);
        check_eq("t2_multi_grant", multi_grant, 0);
        check_eq("t2_beats", tag_log.size(), 64);
        bad = 0;
        foreach (tag_log[k]) if (tag_log[k] != ((k / 8) % 4)) bad++;
        check_eq("t2_tag_seq", bad, 0);
        check_eq("t2_cpl_count", cpl_log.size(), 8);
        bad = 0;
        foreach (cpl_log[k]) if (cpl_log[k] != (1 << (k % 4))) bad++;
        check_eq("t2_cpl_seq", bad, 0);
        check_eq("t2_cfg3_addr", cfg_addr_log[3], 32'h4300);

        // Test 3: zero-length descriptor on requester 1.
        do_reset("t3_rst");
        addr_tab[1] = 32'h3000; len_tab[1] = 0; pend[1] = 1;
        repeat (10) one_cycle();
        check_eq("t3_grant_count", grant_log.size(), 1);
        check_eq("t3_grant_idx", grant_log[0], 1);
        check_eq("t3_cpl_count", cpl_log.size(), 1);
        check_eq("t3_cpl_vec", cpl_log[0], 4'b0010);
        check_eq("t3_cpl_delay", cpl_cyc[0] - grant_cyc[0], 1);
        check_eq("t3_cfg_never", cfg_valid_cycles, 0);
        check_eq("t3_busy_end", busy, 0);

        // Test 4: output stalled, six 4-word descriptors against four tags.
        do_reset("t4_rst");
        for (int i = 0; i < NumReq; i++) begin
            addr_tab[i] = 32'h8000 + 32'(i) * 32'h40; len_tab[i] = 4;
        end
        pend[0] = 2; pend[1] = 2; pend[2] = 1; pend[3] = 1;
        stall = 1'b1;
        repeat (30) one_cycle();
        check_eq("t4_stalled_cfg", cfg_addr_log.size(), 4);
        check_eq("t4_stalled_grants", grant_log.size(), 4);
        check_eq("t4_stalled_busy", busy, 1);
        check_eq("t4_stalled_tag_valid", s_tag_valid, 1);
        stall = 1'b0;
        repeat (60) one_cycle();
        check_eq("t4_total_cfg", cfg_addr_log.size(), 6);
        check_eq("t4_issue_after_pop", (cfg_cyc[4] > eof_cyc[0]), 1);
        check_eq("t4_cpl_count", cpl_log.size(), 6);
        bad = 0;
        foreach (grant_log[k]) if (grant_log[k] != (k % 4)) bad++;
        check_eq("t4_grant_order", bad, 0);
        check_eq("t4_busy_end", busy, 0);

        // Test 5: engine holds cfg_ready low.
        do_reset("t5_rst");
        addr_tab[0] = 32'h5555_0000; len_tab[0] = 7; pend[0] = 1;
        cfg_rdy = 1'b0;
        for (int k = 0; k < 10 && !s_cfg_valid; k++) one_cycle();
        check_eq("t5_valid_seen", s_cfg_valid, 1);
        bad = 0;
        repeat (10) begin
            one_cycle();
            if (!(s_cfg_valid && s_cfg_addr == 32'h5555_0000 && s_cfg_len == 7 && !s_tag_valid))
                bad++;
        end
        check_eq("t5_stable", bad, 0);
        cfg_rdy = 1'b1;
        repeat (20) one_cycle();
        check_eq("t5_cfg_count", cfg_addr_log.size(), 1);
        check_eq("t5_beats", tag_log.size(), 7);
        check_eq("t5_cpl", cpl_log[0], 4'b0001);

        // Test 6: asynchronous reset with three tags queued.
        do_reset("t6_rst");
        for (int i = 1; i < NumReq; i++) begin
            addr_tab[i] = 32'h9000 + 32'(i); len_tab[i] = 4; pend[i] = 1;
        end
        stall = 1'b1;
        repeat (15) one_cycle();
        check_eq("t6_queued_cfg", cfg_addr_log.size(), 3);
        check_eq("t6_queued_busy", busy, 1);
        #3;
        req_valid = '1;
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_cfg_valid", dma_cfg_valid, 0);
        check_eq("t6_async_req_ready", req_ready, 0);
        check_eq("t6_async_cpl", cpl, 0);
        check_eq("t6_async_busy", busy, 0);
        check_eq("t6_async_tag_valid", dout_tag_valid, 0);
        check_eq("t6_async_tag", dout_tag, 0);
        clear_model();
        @(posedge clk);
        #1;
        release_reset();
        addr_tab[0] = 32'hA000; len_tab[0] = 2; pend[0] = 1;
        addr_tab[3] = 32'hA300; len_tab[3] = 2; pend[3] = 1;
        repeat (20) one_cycle();
        check_eq("t6_first_grant", grant_log[0], 0);
        check_eq("t6_beats", tag_log.size(), 4);
        check_eq("t6_first_tag", tag_log[0], 0);
        check_eq("t6_third_tag", tag_log[2], 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
